// File: rtl/timer_pkg.sv
// Shared types and helpers for the MM:SS.cc BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t min_t;
        bcd_digit_t min_u;
        bcd_digit_t sec_t;
        bcd_digit_t sec_u;
        bcd_digit_t cs_t;
        bcd_digit_t cs_u;
    } display_t;

    localparam bcd_digit_t DIG_LIM_TENS  = 4'd5;
    localparam bcd_digit_t DIG_LIM_UNITS = 4'd9;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d, input bcd_digit_t lim);
        return (d > lim) ? lim : d;
    endfunction

    // Saturate each preset digit to the largest value its position can show.
    function automatic display_t clamp_preset(input display_t p);
        display_t r;
        r.min_t = clamp_digit(p.min_t, DIG_LIM_TENS);
        r.min_u = clamp_digit(p.min_u, DIG_LIM_UNITS);
        r.sec_t = clamp_digit(p.sec_t, DIG_LIM_TENS);
        r.sec_u = clamp_digit(p.sec_u, DIG_LIM_UNITS);
        r.cs_t  = clamp_digit(p.cs_t,  DIG_LIM_UNITS);
        r.cs_u  = clamp_digit(p.cs_u,  DIG_LIM_UNITS);
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command and display bundle between the timer and its controller.
interface countdown_timer_if;
    import timer_pkg::*;

    logic     tick;
    logic     load;
    display_t preset;
    logic     start;
    logic     pause;
    logic     clear;
    display_t digits;
    logic     running;
    logic     done;
    logic     alarm;

    modport master (
        output tick, load, preset, start, pause, clear,
        input  digits, running, done, alarm
    );

    modport slave (
        input  tick, load, preset, start, pause, clear,
        output digits, running, done, alarm
    );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps to LIMIT and borrows when decremented at zero.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter bcd_digit_t LIMIT = DIG_LIM_UNITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       en,
    input  logic       clear,
    output bcd_digit_t value,
    output logic       borrow
);

    bcd_digit_t value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_val;
        end else if (en) begin
            value_d = (value_q == '0) ? LIMIT : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign borrow = en & (value_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Six-digit BCD countdown timer with done pulse and tick-stretched alarm.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned ALARM_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    countdown_timer_if.slave bus
);

    localparam int unsigned NUM_DIG = 6;
    localparam int unsigned CNT_W   = $clog2(ALARM_LEN + 1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       running_q, done_q, alarm_q;
    logic                       done_d;
    logic                       dec_c, dig_load_c;
    logic                       clear_c, load_c, pause_c, start_c;
    logic                       is_zero_c, is_one_c;
    logic [NUM_DIG-1:0][3:0]    dig_c;
    logic [NUM_DIG-1:0][3:0]    preset_cl_c;
    logic [NUM_DIG-1:0]         borrow_c;
    logic [NUM_DIG:0]           en_c;

    // Strict command priority: clear > load > pause > start.
    assign clear_c = bus.clear;
    assign load_c  = bus.load  & ~bus.clear;
    assign pause_c = bus.pause & ~bus.clear & ~bus.load;
    assign start_c = bus.start & ~bus.clear & ~bus.load & ~bus.pause;

    assign preset_cl_c = clamp_preset(bus.preset);
    assign is_zero_c   = (dig_c == 24'h000000);
    assign is_one_c    = (dig_c == 24'h000001);

    // Borrow chain from hundredths upward; every digit settles on the same edge.
    assign en_c[0] = dec_c;
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        bcd_down_digit #(
            .LIMIT((i == 3 || i == 5) ? DIG_LIM_TENS : DIG_LIM_UNITS)
        ) u_dig (
            .clk      (clk),
            .rst      (rst),
            .load     (dig_load_c),
            .load_val (preset_cl_c[i]),
            .en       (en_c[i]),
            .clear    (clear_c),
            .value    (dig_c[i]),
            .borrow   (borrow_c[i])
        );
        assign en_c[i+1] = borrow_c[i];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dec_c      = 1'b0;
        dig_load_c = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_c) begin
                    dig_load_c = 1'b1;
                end else if (start_c && !is_zero_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clear_c) begin
                    state_d = IDLE;
                end else if (pause_c) begin
                    state_d = PAUSE;
                end else if (is_zero_c) begin
                    state_d = IDLE;
                end else if (bus.tick) begin
                    dec_c = 1'b1;
                    if (is_one_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            PAUSE: begin
                if (clear_c) begin
                    state_d = IDLE;
                end else if (load_c) begin
                    dig_load_c = 1'b1;
                end else if (start_c) begin
                    // Resuming from zero would underflow on the next tick.
                    state_d = is_zero_c ? IDLE : RUN;
                end
            end
            DONE: begin
                if (clear_c || start_c) begin
                    state_d = IDLE;
                end else if (load_c) begin
                    state_d    = IDLE;
                    dig_load_c = 1'b1;
                end else if (bus.tick) begin
                    if (cnt_q == CNT_W'(ALARM_LEN - 1)) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == RUN);
            done_q    <= done_d;
            alarm_q   <= (state_d == DONE);
        end
    end

    assign bus.digits  = display_t'(dig_c);
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.alarm   = alarm_q;

endmodule
